// File: rtl/vram_cpu_port_sequencer_if.sv
// Bundle between the CPU data/address port logic, the sequencer and the VRAM arbiter.
// The sequencer takes the master modport; the CPU/arbiter side takes the slave modport.
interface vram_cpu_port_sequencer_if #(
  parameter int FIFO_DEPTH = 4
) ();
  logic                          cpu_wr_stb;
  logic [7:0]                    cpu_wr_data;
  logic                          cpu_rd_stb;
  logic                          cpu_addr_set_stb;
  logic                          cpu_addr_rd_mode;
  logic                          VDPVRAMWRREQ;
  logic                          VDPVRAMWRACK;
  logic [7:0]                    VDPVRAMACCESSDATA;
  logic                          VDPVRAMADDRSETREQ;
  logic                          VDPVRAMADDRSETACK;
  logic                          VDPVRAMRDREQ;
  logic                          VDPVRAMRDACK;
  logic                          vram_rd_valid;
  logic [7:0]                    vram_rd_data;
  logic [7:0]                    cpu_rd_data;
  logic                          cpu_wait;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          overflow;

  modport master (
    input  cpu_wr_stb, cpu_wr_data, cpu_rd_stb, cpu_addr_set_stb, cpu_addr_rd_mode,
    input  VDPVRAMWRACK, VDPVRAMADDRSETACK, VDPVRAMRDACK, vram_rd_valid, vram_rd_data,
    output VDPVRAMWRREQ, VDPVRAMACCESSDATA, VDPVRAMADDRSETREQ, VDPVRAMRDREQ,
    output cpu_rd_data, cpu_wait, fifo_level, overflow
  );

  modport slave (
    output cpu_wr_stb, cpu_wr_data, cpu_rd_stb, cpu_addr_set_stb, cpu_addr_rd_mode,
    output VDPVRAMWRACK, VDPVRAMADDRSETACK, VDPVRAMRDACK, vram_rd_valid, vram_rd_data,
    input  VDPVRAMWRREQ, VDPVRAMACCESSDATA, VDPVRAMADDRSETREQ, VDPVRAMRDREQ,
    input  cpu_rd_data, cpu_wait, fifo_level, overflow
  );
endinterface

// File: rtl/vram_cpu_port_sequencer.sv
// Serialises CPU VRAM data-port traffic (buffered writes, address sets, read prefetch)
// onto toggle req/ack handshakes towards the VRAM arbiter, one request in flight at a time.
module vram_cpu_port_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           CLK21M,
  input  logic                           RESET,
  vram_cpu_port_sequencer_if.master      bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR_WAIT = 2'd1;
  localparam logic [1:0] ST_AS_WAIT = 2'd2;
  localparam logic [1:0] ST_RD_WAIT = 2'd3;

  logic [1:0]       state_r, state_s;
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0] level_r, level_s;
  logic             wr_req_r, wr_req_s;
  logic             as_req_r, as_req_s;
  logic             rd_req_r, rd_req_s;
  logic [7:0]       access_data_r, access_data_s;
  logic [7:0]       rd_data_r, rd_data_s;
  logic             cpu_wait_r, cpu_wait_s;
  logic             overflow_r, overflow_s;
  logic             as_pend_r, as_pend_s, as_pend_f_s;
  logic             rd_mode_r, rd_mode_s;
  logic             pf_pend_r, pf_pend_s, pf_pend_f_s;
  logic             pf_again_r, pf_again_s, pf_again_f_s;
  logic             rd_seen_r, rd_seen_s;
  logic             push_s, pop_s;

  // Request sequencing FSM, FIFO bookkeeping and pend-flag updates.
  always_comb begin
    push_s        = bus.cpu_wr_stb & ~cpu_wait_r;
    pop_s         = 1'b0;
    state_s       = state_r;
    wr_req_s      = wr_req_r;
    as_req_s      = as_req_r;
    rd_req_s      = rd_req_r;
    access_data_s = access_data_r;
    rd_data_s     = rd_data_r;
    rd_seen_s     = rd_seen_r;
    as_pend_f_s   = as_pend_r;
    pf_pend_f_s   = pf_pend_r;
    pf_again_f_s  = pf_again_r;

    case (state_r)
      ST_IDLE: begin
        if (level_r != LVL_ZERO) begin
          wr_req_s      = ~wr_req_r;
          access_data_s = mem_r[rd_ptr_r];
          state_s       = ST_WR_WAIT;
        end else if (as_pend_r) begin
          as_req_s = ~as_req_r;
          state_s  = ST_AS_WAIT;
        end else if (pf_pend_r) begin
          rd_req_s     = ~rd_req_r;
          rd_seen_s    = 1'b0;
          pf_again_f_s = 1'b0;
          state_s      = ST_RD_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        if (bus.VDPVRAMWRACK == wr_req_r) begin
          pop_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WR_WAIT;
        end
      end
      ST_AS_WAIT: begin
        if (bus.VDPVRAMADDRSETACK == as_req_r) begin
          as_pend_f_s = 1'b0;
          pf_pend_f_s = pf_pend_r | rd_mode_r;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_AS_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (bus.vram_rd_valid) begin
          rd_data_s = bus.vram_rd_data;
          rd_seen_s = 1'b1;
        end else begin
          rd_seen_s = rd_seen_r;
        end
        // Data may land before, with or after the ack; leave only once both happened.
        if ((bus.VDPVRAMRDACK == rd_req_r) && (rd_seen_r || bus.vram_rd_valid)) begin
          pf_pend_f_s  = pf_again_r;
          pf_again_f_s = 1'b0;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_RD_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // The in-flight prefetch stays pending until RD_WAIT exits; a strobe meanwhile arms one more.
    as_pend_s  = bus.cpu_addr_set_stb | as_pend_f_s;
    rd_mode_s  = bus.cpu_addr_set_stb ? bus.cpu_addr_rd_mode : rd_mode_r;
    pf_again_s = (bus.cpu_rd_stb && (state_s == ST_RD_WAIT)) ? 1'b1 :
                 (bus.cpu_addr_set_stb ? 1'b0 : pf_again_f_s);
    pf_pend_s  = (bus.cpu_rd_stb && (state_s != ST_RD_WAIT)) ? 1'b1 :
                 ((bus.cpu_addr_set_stb && (state_s != ST_RD_WAIT)) ? 1'b0 : pf_pend_f_s);

    case ({push_s, pop_s})
      2'b10:   level_s = level_r + LVL_W'(1);
      2'b01:   level_s = level_r - LVL_W'(1);
      default: level_s = level_r;
    endcase

    cpu_wait_s = (level_s == LVL_FULL) | as_pend_s;
    overflow_s = overflow_r | (bus.cpu_wr_stb & cpu_wait_r);
  end

  // State, handshake and output registers.
  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      state_r       <= ST_IDLE;
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      level_r       <= LVL_ZERO;
      wr_req_r      <= 1'b0;
      as_req_r      <= 1'b0;
      rd_req_r      <= 1'b0;
      access_data_r <= 8'h00;
      rd_data_r     <= 8'h00;
      cpu_wait_r    <= 1'b0;
      overflow_r    <= 1'b0;
      as_pend_r     <= 1'b0;
      rd_mode_r     <= 1'b0;
      pf_pend_r     <= 1'b0;
      pf_again_r    <= 1'b0;
      rd_seen_r     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      state_r       <= state_s;
      level_r       <= level_s;
      wr_req_r      <= wr_req_s;
      as_req_r      <= as_req_s;
      rd_req_r      <= rd_req_s;
      access_data_r <= access_data_s;
      rd_data_r     <= rd_data_s;
      cpu_wait_r    <= cpu_wait_s;
      overflow_r    <= overflow_s;
      as_pend_r     <= as_pend_s;
      rd_mode_r     <= rd_mode_s;
      pf_pend_r     <= pf_pend_s;
      pf_again_r    <= pf_again_s;
      rd_seen_r     <= rd_seen_s;
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.cpu_wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  assign bus.VDPVRAMWRREQ      = wr_req_r;
  assign bus.VDPVRAMADDRSETREQ = as_req_r;
  assign bus.VDPVRAMRDREQ      = rd_req_r;
  assign bus.VDPVRAMACCESSDATA = access_data_r;
  assign bus.cpu_rd_data       = rd_data_r;
  assign bus.cpu_wait          = cpu_wait_r;
  assign bus.fifo_level        = level_r;
  assign bus.overflow          = overflow_r;

endmodule

// File: tb/tb_vram_cpu_port_sequencer.sv
// Directed bench: a vector table for write buffering/overflow, plus hand-written
// sequences for address-set ordering, read capture timing, prefetch merge and reset.
module tb_vram_cpu_port_sequencer;
  localparam int DEPTH = 4;

  logic CLK21M = 1'b0;
  logic RESET  = 1'b1;
  always #5 CLK21M = ~CLK21M;

  vram_cpu_port_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();
  vram_cpu_port_sequencer #(.FIFO_DEPTH(DEPTH)) dut (.CLK21M(CLK21M), .RESET(RESET), .bus(bus));

  typedef struct {
    logic       wr_stb;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic [2:0] lvl;
    logic       wt;
    logic       ovf;
    logic       wrreq;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [25];
  int checks = 0;
  int errors = 0;
  int wr_tog, as_tog, rd_tog, as_wr_at, as_lvl_at, rd_as_at;
  logic [7:0] wr_seen [$];

  function automatic vec_t mk(input logic w, input logic [7:0] d, input logic a, input logic [2:0] l,
                              input logic wt, input logic o, input logic r, input logic [7:0] dt);
    vec_t v;
    v.wr_stb = w; v.wr_data = d; v.wr_ack = a; v.lvl = l;
    v.wt = wt; v.ovf = o; v.wrreq = r; v.data = dt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    wr_tog = 0; as_tog = 0; rd_tog = 0;
    as_wr_at = -1; as_lvl_at = -1; rd_as_at = -1;
    wr_seen.delete();
  endtask

  // One clock: sample just after the edge, log request toggles, then drop the strobes.
  task automatic tick();
    logic w, a, r;
    w = bus.VDPVRAMWRREQ; a = bus.VDPVRAMADDRSETREQ; r = bus.VDPVRAMRDREQ;
    @(posedge CLK21M);
    #1;
    if (bus.VDPVRAMWRREQ !== w) begin
      wr_tog++;
      wr_seen.push_back(bus.VDPVRAMACCESSDATA);
    end
    if (bus.VDPVRAMADDRSETREQ !== a) begin
      as_tog++;
      as_wr_at  = wr_tog;
      as_lvl_at = int'(bus.fifo_level);
    end
    if (bus.VDPVRAMRDREQ !== r) begin
      rd_tog++;
      rd_as_at = as_tog;
    end
    bus.cpu_wr_stb = 1'b0; bus.cpu_rd_stb = 1'b0; bus.cpu_addr_set_stb = 1'b0;
    bus.vram_rd_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " wrreq"},   bus.VDPVRAMWRREQ, 0);
    chk({tag, " asreq"},   bus.VDPVRAMADDRSETREQ, 0);
    chk({tag, " rdreq"},   bus.VDPVRAMRDREQ, 0);
    chk({tag, " data"},    bus.VDPVRAMACCESSDATA, 0);
    chk({tag, " rd_data"}, bus.cpu_rd_data, 0);
    chk({tag, " level"},   bus.fifo_level, 0);
    chk({tag, " ovf"},     bus.overflow, 0);
    chk({tag, " wait"},    bus.cpu_wait, 0);
  endtask

  task automatic do_reset(input string tag);
    RESET = 1'b1;
    bus.cpu_wr_stb = 1'b0; bus.cpu_wr_data = 8'h00; bus.cpu_rd_stb = 1'b0;
    bus.cpu_addr_set_stb = 1'b0; bus.cpu_addr_rd_mode = 1'b0;
    bus.VDPVRAMWRACK = 1'b0; bus.VDPVRAMADDRSETACK = 1'b0; bus.VDPVRAMRDACK = 1'b0;
    bus.vram_rd_valid = 1'b0; bus.vram_rd_data = 8'h00;
    @(posedge CLK21M);
    #1;
    chk_reset_outputs(tag);
    @(negedge CLK21M);
    RESET = 1'b0;
    clear_counts();
    tick();
    chk({tag, " no toggle after release"}, wr_tog + as_tog + rd_tog, 0);
  endtask

  // Arbiter stand-in: acks one cycle after each request, read data with the read ack.
  task automatic resp(input logic [7:0] rbyte, input int n);
    for (int k = 0; k < n; k++) begin
      bus.VDPVRAMWRACK      = bus.VDPVRAMWRREQ;
      bus.VDPVRAMADDRSETACK = bus.VDPVRAMADDRSETREQ;
      if (bus.VDPVRAMRDREQ !== bus.VDPVRAMRDACK) begin
        bus.VDPVRAMRDACK  = bus.VDPVRAMRDREQ;
        bus.vram_rd_valid = 1'b1;
        bus.vram_rd_data  = rbyte;
      end
      tick();
    end
  endtask

  initial begin
    // Three back-to-back writes, acked two cycles after each request.
    vecs[0]  = mk(1'b1, 8'h11, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[1]  = mk(1'b1, 8'h22, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 8'h11);
    vecs[2]  = mk(1'b1, 8'h33, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'h11);
    vecs[3]  = mk(1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 8'h11);
    vecs[4]  = mk(1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'h22);
    vecs[5]  = mk(1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'h22);
    vecs[6]  = mk(1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'h22);
    vecs[7]  = mk(1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 8'h33);
    vecs[8]  = mk(1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 8'h33);
    vecs[9]  = mk(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h33);
    vecs[10] = mk(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h33);
    // Five writes with the ack withheld: fill to 4, drop the fifth, then drain.
    vecs[11] = mk(1'b1, 8'h01, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 8'h33);
    vecs[12] = mk(1'b1, 8'h02, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'h01);
    vecs[13] = mk(1'b1, 8'h03, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'h01);
    vecs[14] = mk(1'b1, 8'h04, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'h01);
    vecs[15] = mk(1'b1, 8'h05, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 8'h01);
    vecs[16] = mk(1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 8'h01);
    vecs[17] = mk(1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'h01);
    vecs[18] = mk(1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 8'h02);
    vecs[19] = mk(1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 8'h02);
    vecs[20] = mk(1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 8'h03);
    vecs[21] = mk(1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 8'h03);
    vecs[22] = mk(1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 8'h04);
    vecs[23] = mk(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 8'h04);
    vecs[24] = mk(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 8'h04);

    do_reset("rst0");
    for (int i = 0; i < 25; i++) begin
      bus.cpu_wr_stb   = vecs[i].wr_stb;
      bus.cpu_wr_data  = vecs[i].wr_data;
      bus.VDPVRAMWRACK = vecs[i].wr_ack;
      tick();
      chk($sformatf("v%0d level", i), bus.fifo_level, vecs[i].lvl);
      chk($sformatf("v%0d wait", i), bus.cpu_wait, vecs[i].wt);
      chk($sformatf("v%0d overflow", i), bus.overflow, vecs[i].ovf);
      chk($sformatf("v%0d wrreq", i), bus.VDPVRAMWRREQ, vecs[i].wrreq);
      chk($sformatf("v%0d data", i), bus.VDPVRAMACCESSDATA, vecs[i].data);
    end

    // Writes then a read-mode address set: drain, address, prefetch.
    do_reset("rst1");
    bus.cpu_wr_stb = 1'b1; bus.cpu_wr_data = 8'hAA; tick();
    bus.cpu_wr_stb = 1'b1; bus.cpu_wr_data = 8'hBB; tick();
    bus.cpu_addr_set_stb = 1'b1; bus.cpu_addr_rd_mode = 1'b1; tick();
    chk("as wait during addr pend", bus.cpu_wait, 1);
    resp(8'hA5, 12);
    chk("as wr toggles", wr_tog, 2);
    if (wr_seen.size() == 2) begin
      chk("as wr data 0", wr_seen[0], 8'hAA);
      chk("as wr data 1", wr_seen[1], 8'hBB);
    end
    chk("as toggles", as_tog, 1);
    chk("as after both writes", as_wr_at, 2);
    chk("as fifo empty at addr", as_lvl_at, 0);
    chk("as rd toggles", rd_tog, 1);
    chk("as rd after addr", rd_as_at, 1);
    chk("as rd data", bus.cpu_rd_data, 8'hA5);
    chk("as wait released", bus.cpu_wait, 0);

    // Read data arriving before the ack; FSM must hold RD_WAIT until the ack.
    do_reset("rst2");
    bus.cpu_rd_stb = 1'b1; tick();
    tick();
    chk("early rd toggle", rd_tog, 1);
    bus.vram_rd_valid = 1'b1; bus.vram_rd_data = 8'h3C; tick();
    chk("early rd data", bus.cpu_rd_data, 8'h3C);
    bus.cpu_wr_stb = 1'b1; bus.cpu_wr_data = 8'h77; tick();
    tick();
    chk("early hold no wr", wr_tog, 0);
    chk("early level", bus.fifo_level, 1);
    bus.VDPVRAMRDACK = bus.VDPVRAMRDREQ; tick();
    chk("early exit cycle no wr", wr_tog, 0);
    tick();
    chk("early wr after exit", wr_tog, 1);
    chk("early single rd", rd_tog, 1);
    if (wr_seen.size() == 1) chk("early wr data", wr_seen[0], 8'h77);

    // Two read strobes during RD_WAIT merge into one further read.
    do_reset("rst3");
    bus.cpu_rd_stb = 1'b1; tick();
    tick();
    bus.cpu_rd_stb = 1'b1; tick();
    bus.cpu_rd_stb = 1'b1; tick();
    chk("merge rd before ack", rd_tog, 1);
    bus.VDPVRAMRDACK = bus.VDPVRAMRDREQ; bus.vram_rd_valid = 1'b1; bus.vram_rd_data = 8'h5A; tick();
    chk("merge first data", bus.cpu_rd_data, 8'h5A);
    resp(8'hC3, 8);
    chk("merge rd toggles", rd_tog, 2);
    chk("merge second data", bus.cpu_rd_data, 8'hC3);

    // Reset while a write is outstanding with two entries buffered.
    do_reset("rst4");
    bus.cpu_wr_stb = 1'b1; bus.cpu_wr_data = 8'h11; tick();
    bus.cpu_wr_stb = 1'b1; bus.cpu_wr_data = 8'h22; tick();
    chk("midrst level", bus.fifo_level, 2);
    chk("midrst wrreq", bus.VDPVRAMWRREQ, 1);
    #2;
    RESET = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(posedge CLK21M);
    @(negedge CLK21M);
    RESET = 1'b0;
    clear_counts();
    tick();
    tick();
    chk("midrst no stale toggle", wr_tog + as_tog + rd_tog, 0);
    chk("midrst level after", bus.fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_cpu_port_sequencer.md
VRAM_CPU_PORT_SEQUENCER -- requirements
Module: vram_cpu_port_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, CPU write-buffer entries; SHALL be a power of 2, at least 2.
REQ-002 CLK21M  in  1  single clock; all state SHALL change on its rising edge only.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 cpu_wr_stb  in  1  one-cycle pulse, CPU VRAM data-port write.
REQ-005 cpu_wr_data  in  8  byte qualified by cpu_wr_stb.
REQ-006 cpu_rd_stb  in  1  one-cycle pulse, CPU consumed cpu_rd_data; requests next prefetch.
REQ-007 cpu_addr_set_stb  in  1  one-cycle pulse, CPU completed an address write.
REQ-008 cpu_addr_rd_mode  in  1  qualified by cpu_addr_set_stb; 1 = address set for reading.
REQ-009 VDPVRAMWRREQ  out  1  write toggle-request to the arbiter.
REQ-010 VDPVRAMWRACK  in  1  write toggle-acknowledge.
REQ-011 VDPVRAMACCESSDATA  out  8  byte for the outstanding write.
REQ-012 VDPVRAMADDRSETREQ  out  1  address-set toggle-request.
REQ-013 VDPVRAMADDRSETACK  in  1  address-set toggle-acknowledge.
REQ-014 VDPVRAMRDREQ  out  1  read toggle-request.
REQ-015 VDPVRAMRDACK  in  1  read toggle-acknowledge.
REQ-016 vram_rd_valid  in  1  one-cycle pulse, read byte returned.
REQ-017 vram_rd_data  in  8  byte qualified by vram_rd_valid.
REQ-018 cpu_rd_data  out  8  prefetched read byte.
REQ-019 cpu_wait  out  1  CPU writes are refused this cycle.
REQ-020 fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently buffered.
REQ-021 overflow  out  1  sticky flag: a write was dropped.

Function
REQ-022 Every toggle request SHALL be outstanding while REQ != ACK; at most one request of any kind SHALL be outstanding at a time.
REQ-023 The FSM SHALL have states IDLE, WR_WAIT, AS_WAIT and RD_WAIT.
REQ-024 IDLE priority: FIFO non-empty -> toggle WRREQ, go to WR_WAIT; else addr_set_pend -> toggle ADDRSETREQ, go to AS_WAIT; else prefetch_pend -> toggle RDREQ, go to RD_WAIT.
REQ-025 VDPVRAMACCESSDATA SHALL equal the FIFO head and stay stable throughout WR_WAIT.
REQ-026 WR_WAIT: when WRACK equals WRREQ -> pop the head, return to IDLE; no new request SHALL issue in that same cycle.
REQ-027 AS_WAIT: when ACK equals REQ -> clear addr_set_pend; set prefetch_pend if the latched rd_mode is 1; return to IDLE.
REQ-028 RD_WAIT: capture vram_rd_data into cpu_rd_data on vram_rd_valid, whether it arrives before, with, or after the ack match.
REQ-029 RD_WAIT: exit to IDLE only once both the ack match and the data capture have occurred; clear prefetch_pend at exit unless it was re-set during RD_WAIT.
REQ-030 cpu_rd_stb SHALL set prefetch_pend in any state; a second strobe while pending SHALL merge (one-deep).
REQ-031 cpu_addr_set_stb SHALL set addr_set_pend, latch rd_mode, and clear any not-yet-issued prefetch_pend.
REQ-032 cpu_wait SHALL equal (fifo_level == FIFO_DEPTH) OR addr_set_pend.
REQ-033 cpu_wr_stb while cpu_wait=1 SHALL drop the byte, set overflow, and leave the FIFO unchanged.
REQ-034 A push and a pop in the same cycle SHALL leave fifo_level unchanged and preserve order.
REQ-035 FIFO pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-036 Writes accepted before an address set SHALL complete before ADDRSETREQ toggles, because FIFO drain has priority.
REQ-037 A read SHALL never issue while the FIFO is non-empty.

Reset
REQ-038 On RESET (including mid-transaction), outputs SHALL be: VDPVRAMWRREQ=0, VDPVRAMADDRSETREQ=0, VDPVRAMRDREQ=0, VDPVRAMACCESSDATA=0, cpu_rd_data=0, fifo_level=0, overflow=0, cpu_wait=0.
REQ-039 On RESET, state SHALL be IDLE, FIFO empty, pointers 0, and pend flags clear; no toggle SHALL occur in the first cycle after release.

Verification
REQ-040 Writes 0x11, 0x22, 0x33 back-to-back, ack 2 cycles after each req -> three WRREQ toggles, data presented in order, fifo_level 3->0.
REQ-041 Five writes with FIFO_DEPTH=4 and WRACK withheld -> cpu_wait=1 at level 4, fifth byte dropped, overflow=1, level stays 4.
REQ-042 Two writes then address set with rd_mode=1 -> both writes acked before ADDRSETREQ toggles, then RDREQ toggles; vram_rd_data=0xA5 -> cpu_rd_data=0xA5.
REQ-043 vram_rd_valid arriving one cycle before RDACK -> data captured, FSM stays in RD_WAIT until the ack, then returns to IDLE.
REQ-044 cpu_rd_stb twice during RD_WAIT -> exactly one further RDREQ toggle after completion.
REQ-045 RESET asserted during WR_WAIT with level 2 -> all outputs at reset values immediately; no stale toggle after release.
